// File: rtl/character_motion_ctl.sv
// character_motion_ctl
// Per-frame movement state machine for the player sprite: walk (with ramp
// following), ladder climb, jump and fall. Position/state advance only on
// clock edges where tick=1; outputs hold between ticks.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   tick                       one-cycle movement strobe (once per frame)
//   btn_left/right/up/down     level button inputs (already synchronised)
//   btn_jump                   jump request
//   ladder                     sprite overlaps a ladder
//   ramp[1:0]                  01 rises right, 10 rises left, 00 flat
//   limit_ypos_min/max         top/bottom stop of current ladder
//   end_of_ramp                sprite walked off a ramp edge
//   landing_ypos               y to land on after a fall
//   xpos, ypos                 registered sprite position
//   state                      0 WALK, 1 CLIMB, 2 JUMP, 3 FALL
//   facing                     0 left, 1 right
//
// Build option: define AIR_CONTROL_EN to allow left/right steering while in
// JUMP/FALL. Without it xpos and facing are frozen in the air.
module character_motion_ctl #(
    parameter int X_INIT     = 64,
    parameter int Y_INIT     = 655,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 976,
    parameter int WALK_STEP  = 2,
    parameter int CLIMB_STEP = 2,
    parameter int RAMP_DIV   = 8,
    parameter int JUMP_V0    = -10,
    parameter int GRAVITY    = 1,
    parameter int FALL_VMAX  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_jump,
    input  logic        ladder,
    input  logic [1:0]  ramp,
    input  logic [11:0] limit_ypos_min,
    input  logic [11:0] limit_ypos_max,
    input  logic        end_of_ramp,
    input  logic [11:0] landing_ypos,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [2:0]  state,
    output logic        facing
);

    typedef enum logic [2:0] {
        ST_WALK  = 3'd0,
        ST_CLIMB = 3'd1,
        ST_JUMP  = 3'd2,
        ST_FALL  = 3'd3
    } state_t;

    // 14-bit signed intermediates: one bit of headroom over 13 so that
    // 4095 + a positive velocity cannot wrap before saturation.
    localparam logic [11:0]        X_INIT_C   = 12'(X_INIT);
    localparam logic [11:0]        Y_INIT_C   = 12'(Y_INIT);
    localparam logic signed [13:0] X_MIN_S    = 14'(X_MIN);
    localparam logic signed [13:0] X_MAX_S    = 14'(X_MAX);
    localparam logic signed [13:0] WALK_S     = 14'(WALK_STEP);
    localparam logic signed [13:0] CLIMB_S    = 14'(CLIMB_STEP);
    localparam logic signed [7:0]  JUMP_V0_S  = 8'(JUMP_V0);
    localparam logic signed [7:0]  GRAV_S     = 8'(GRAVITY);
    localparam logic signed [7:0]  VMAX_S     = 8'(FALL_VMAX);
    localparam logic [4:0]         RAMP_DIV_C = 5'(RAMP_DIV);
    localparam logic [4:0]         WALK_CNT   = 5'(WALK_STEP);

    function automatic logic signed [13:0] ext_pos(input logic [11:0] p);
        return $signed({2'b00, p});
    endfunction

    function automatic logic signed [13:0] ext_vel(input logic signed [7:0] v);
        return $signed({{6{v[7]}}, v});
    endfunction

    function automatic logic [11:0] sat12(input logic signed [13:0] v);
        if (v < 14'sd0)
            return 12'd0;
        else if (v > 14'sd4095)
            return 12'hFFF;
        else
            return v[11:0];
    endfunction

    state_t             state_reg, state_next;
    logic [11:0]        x_reg, x_next;
    logic [11:0]        y_reg, y_next;
    logic               facing_reg, facing_next;
    logic signed [7:0]  vel_reg, vel_next;
    logic [4:0]         ramp_cnt_reg, ramp_cnt_next;
    logic [11:0]        land_y_reg, land_y_next;
    logic [11:0]        base_y_reg, base_y_next;

    // scratch values
    logic signed [13:0] x_step, y_s, y_sum;
    logic [11:0]        x_clamped, y_climb, y_air;
    logic               one_dir, x_moves, on_slope, uphill;
    logic [4:0]         cnt_sum;
    logic signed [7:0]  v_inc, v_air;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_WALK;
            x_reg        <= X_INIT_C;
            y_reg        <= Y_INIT_C;
            facing_reg   <= 1'b1;
            vel_reg      <= '0;
            ramp_cnt_reg <= '0;
            land_y_reg   <= '0;
            base_y_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            facing_reg   <= facing_next;
            vel_reg      <= vel_next;
            ramp_cnt_reg <= ramp_cnt_next;
            land_y_reg   <= land_y_next;
            base_y_reg   <= base_y_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        facing_next   = facing_reg;
        vel_next      = vel_reg;
        ramp_cnt_next = ramp_cnt_reg;
        land_y_next   = land_y_reg;
        base_y_next   = base_y_reg;

        // Horizontal candidate shared by walking and (optionally) air control.
        one_dir  = btn_left ^ btn_right;
        x_step   = btn_right ? (ext_pos(x_reg) + WALK_S) : (ext_pos(x_reg) - WALK_S);
        if (x_step < X_MIN_S)
            x_clamped = X_MIN_S[11:0];
        else if (x_step > X_MAX_S)
            x_clamped = X_MAX_S[11:0];
        else
            x_clamped = x_step[11:0];
        x_moves  = one_dir && (x_clamped != x_reg);
        on_slope = (ramp == 2'b01) || (ramp == 2'b10);
        // Going uphill means y decreases (screen y grows downward).
        uphill   = (ramp == 2'b01) ? btn_right : btn_left;
        cnt_sum  = ramp_cnt_reg + WALK_CNT;

        y_s      = ext_pos(y_reg);
        y_sum    = '0;
        y_climb  = y_reg;
        y_air    = y_reg;
        v_inc    = vel_reg + GRAV_S;
        v_air    = v_inc;

        if (tick) begin
            unique case (state_reg)
                ST_WALK: begin
                    if (!on_slope)
                        ramp_cnt_next = '0;
                    if (end_of_ramp) begin
                        land_y_next = landing_ypos;
                        vel_next    = '0;
                        state_next  = ST_FALL;
                    end else if (ladder && ((btn_up && (y_reg > limit_ypos_min)) ||
                                            (btn_down && (y_reg < limit_ypos_max)))) begin
                        state_next = ST_CLIMB;
                    end else if (btn_jump) begin
                        base_y_next = y_reg;
                        vel_next    = JUMP_V0_S;
                        state_next  = ST_JUMP;
                    end else if (one_dir) begin
                        x_next      = x_clamped;
                        facing_next = btn_right;
                        // Blocked moves at the clamp do not advance along the ramp.
                        if (x_moves && on_slope) begin
                            if (cnt_sum >= RAMP_DIV_C) begin
                                ramp_cnt_next = cnt_sum - RAMP_DIV_C;
                                y_next = uphill ? sat12(y_s - 14'sd1) : sat12(y_s + 14'sd1);
                            end else begin
                                ramp_cnt_next = cnt_sum;
                            end
                        end
                    end
                end

                ST_CLIMB: begin
                    if (!ladder) begin
                        state_next = ST_WALK;
                    end else begin
                        if (btn_up && !btn_down) begin
                            y_sum   = y_s - CLIMB_S;
                            y_climb = (y_sum < ext_pos(limit_ypos_min)) ? limit_ypos_min : y_sum[11:0];
                        end else if (btn_down && !btn_up) begin
                            y_sum   = y_s + CLIMB_S;
                            y_climb = (y_sum > ext_pos(limit_ypos_max)) ? limit_ypos_max : y_sum[11:0];
                        end
                        y_next = y_climb;
                        if ((y_climb == limit_ypos_min) || (y_climb == limit_ypos_max))
                            state_next = ST_WALK;
                    end
                end

                ST_JUMP: begin
                    if (end_of_ramp) begin
                        land_y_next = landing_ypos;
                        state_next  = ST_FALL;
                    end else begin
                        y_air = sat12(y_s + ext_vel(vel_reg));
                        // Land when the following step would reach the take-off line.
                        if ((v_inc > 8'sd0) &&
                            (ext_pos(y_air) + ext_vel(v_inc) >= ext_pos(base_y_reg))) begin
                            y_next     = base_y_reg;
                            vel_next   = '0;
                            state_next = ST_WALK;
                        end else begin
                            y_next   = y_air;
                            vel_next = v_inc;
                        end
                    end
                end

                ST_FALL: begin
                    v_air = (v_inc > VMAX_S) ? VMAX_S : v_inc;
                    y_air = sat12(y_s + ext_vel(v_air));
                    if (y_air >= land_y_reg) begin
                        y_next     = land_y_reg;
                        vel_next   = '0;
                        state_next = ST_WALK;
                    end else begin
                        y_next   = y_air;
                        vel_next = v_air;
                    end
                end

                default: begin
                    state_next = ST_WALK;
                end
            endcase

`ifdef AIR_CONTROL_EN
            if (((state_reg == ST_JUMP) || (state_reg == ST_FALL)) && one_dir) begin
                x_next      = x_clamped;
                facing_next = btn_right;
            end
`endif
        end
    end

    assign xpos   = x_reg;
    assign ypos   = y_reg;
    assign state  = state_reg;
    assign facing = facing_reg;

endmodule

// File: tb/tb_character_motion_ctl.sv
// Testbench for character_motion_ctl: directed scenarios (walk, ramp, clamp,
// climb, jump, fall, async reset) followed by randomized ticks, all checked
// against an integer reference model of the movement rules.
module tb_character_motion_ctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic        btn_jump = 1'b0, ladder = 1'b0, end_of_ramp = 1'b0;
    logic [1:0]  ramp = 2'b00;
    logic [11:0] limit_ypos_min = '0, limit_ypos_max = '0, landing_ypos = '0;
    logic [11:0] xpos, ypos;
    logic [2:0]  state;
    logic        facing;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_x, m_y, m_st, m_face, m_vel, m_cnt, m_land, m_base;

    always #5 clk = ~clk;

    character_motion_ctl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .btn_jump       (btn_jump),
        .ladder         (ladder),
        .ramp           (ramp),
        .limit_ypos_min (limit_ypos_min),
        .limit_ypos_max (limit_ypos_max),
        .end_of_ramp    (end_of_ramp),
        .landing_ypos   (landing_ypos),
        .xpos           (xpos),
        .ypos           (ypos),
        .state          (state),
        .facing         (facing)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        m_x = 64; m_y = 655; m_st = 0; m_face = 1;
        m_vel = 0; m_cnt = 0; m_land = 0; m_base = 0;
    endtask

    // One frame of movement, written straight from the movement rules.
    task automatic model_step();
        int st0, nx, ny, nv;
        st0 = m_st;
        case (m_st)
            0: begin
                if (ramp == 2'b00 || ramp == 2'b11) m_cnt = 0;
                if (end_of_ramp) begin
                    m_land = landing_ypos; m_vel = 0; m_st = 3;
                end else if (ladder && ((btn_up && m_y > limit_ypos_min) ||
                                        (btn_down && m_y < limit_ypos_max))) begin
                    m_st = 1;
                end else if (btn_jump) begin
                    m_base = m_y; m_vel = -10; m_st = 2;
                end else if (btn_left != btn_right) begin
                    nx = clampi(btn_right ? m_x + 2 : m_x - 2, 0, 976);
                    m_face = btn_right;
                    if (nx != m_x && (ramp == 2'b01 || ramp == 2'b10)) begin
                        m_cnt += 2;
                        if (m_cnt >= 8) begin
                            m_cnt -= 8;
                            if ((ramp == 2'b01 && btn_right) || (ramp == 2'b10 && btn_left))
                                m_y = clampi(m_y - 1, 0, 4095);
                            else
                                m_y = clampi(m_y + 1, 0, 4095);
                        end
                    end
                    m_x = nx;
                end
            end
            1: begin
                if (!ladder) m_st = 0;
                else begin
                    if (btn_up && !btn_down)
                        m_y = (m_y - 2 < int'(limit_ypos_min)) ? int'(limit_ypos_min) : m_y - 2;
                    else if (btn_down && !btn_up)
                        m_y = (m_y + 2 > int'(limit_ypos_max)) ? int'(limit_ypos_max) : m_y + 2;
                    if (m_y == limit_ypos_min || m_y == limit_ypos_max) m_st = 0;
                end
            end
            2: begin
                if (end_of_ramp) begin
                    m_land = landing_ypos; m_st = 3;
                end else begin
                    ny = clampi(m_y + m_vel, 0, 4095);
                    nv = m_vel + 1;
                    if (nv > 0 && ny + nv >= m_base) begin
                        m_y = m_base; m_vel = 0; m_st = 0;
                    end else begin
                        m_y = ny; m_vel = nv;
                    end
                end
            end
            default: begin
                nv = (m_vel + 1 > 8) ? 8 : m_vel + 1;
                ny = clampi(m_y + nv, 0, 4095);
                if (ny >= m_land) begin
                    m_y = m_land; m_vel = 0; m_st = 0;
                end else begin
                    m_y = ny; m_vel = nv;
                end
            end
        endcase
`ifdef AIR_CONTROL_EN
        if ((st0 == 2 || st0 == 3) && btn_left != btn_right) begin
            m_x = clampi(btn_right ? m_x + 2 : m_x - 2, 0, 976);
            m_face = btn_right;
        end
`else
        if (st0 > 3) m_st = 0;
`endif
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".xpos"},   xpos,   m_x);
        check({tag, ".ypos"},   ypos,   m_y);
        check({tag, ".state"},  state,  m_st);
        check({tag, ".facing"}, facing, m_face);
    endtask

    task automatic do_tick(input string tag);
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        model_step();
        compare_all(tag);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        compare_all("hold");
    endtask

    task automatic clear_inputs();
        btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; btn_jump = 0;
        ladder = 0; end_of_ramp = 0; ramp = 2'b00;
    endtask

    // Reset asserted between clock edges; outputs must change without an edge.
    task automatic apply_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".rst_xpos"},   xpos,   64);
        check({tag, ".rst_ypos"},   ypos,   655);
        check({tag, ".rst_state"},  state,  0);
        check({tag, ".rst_facing"}, facing, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int prev_y;
        model_reset();
        clear_inputs();
        apply_reset("init");

        // Walk right on flat ground
        btn_right = 1;
        for (int i = 0; i < 10; i++) do_tick("walk");
        check("walk_x", xpos, 84);
        check("walk_y", ypos, 655);
        check("walk_face", facing, 1);
        $display("walk: x=%0d y=%0d facing=%0d", xpos, ypos, facing);

        // Ramp rising to the right: 16 px -> 2 px up
        ramp = 2'b01;
        for (int i = 0; i < 8; i++) do_tick("ramp");
        check("ramp_y", ypos, 653);
        $display("ramp: x=%0d y=%0d", xpos, ypos);
        ramp = 2'b00;

        idle_cycles(3);

        // Right clamp, then left clamp
        for (int i = 0; i < 480; i++) do_tick("clampR");
        check("clamp_xmax", xpos, 976);
        btn_right = 0; btn_left = 1;
        for (int i = 0; i < 500; i++) do_tick("clampL");
        check("clamp_xmin", xpos, 0);
        check("clamp_face", facing, 0);
        $display("clamp: x=%0d facing=%0d", xpos, facing);
        btn_left = 0;

        // Ladder climb from 655 to 400
        apply_reset("climb");
        ladder = 1; limit_ypos_min = 12'd400; limit_ypos_max = 12'd655; btn_up = 1;
        do_tick("climb");
        check("climb_enter", state, 1);
        for (int i = 1; i < 200; i++) do_tick("climb");
        check("climb_top", ypos, 400);
        check("climb_exit", state, 0);
        $display("climb: y=%0d state=%0d", ypos, state);
        clear_inputs();

        // Jump from 655: apex 600 after 10 ticks, lands after 20
        apply_reset("jump");
        btn_jump = 1;
        do_tick("jump");
        check("jump_enter", state, 2);
        btn_jump = 0;
        for (int i = 0; i < 10; i++) do_tick("jump");
        check("jump_apex", ypos, 600);
        for (int i = 0; i < 10; i++) do_tick("jump");
        check("jump_land_y", ypos, 655);
        check("jump_land_st", state, 0);
        $display("jump: y=%0d state=%0d", ypos, state);

        // Async reset in mid-jump
        btn_jump = 1;
        do_tick("jump2");
        btn_jump = 0;
        for (int i = 0; i < 5; i++) do_tick("jump2");
        apply_reset("midjump");
        $display("midjump reset: x=%0d y=%0d state=%0d", xpos, ypos, state);

        // Fall from 290 to 479
        ladder = 1; limit_ypos_min = 12'd290; limit_ypos_max = 12'd655; btn_up = 1;
        do_tick("fallprep");
        for (int i = 0; i < 300 && state != 0; i++) do_tick("fallprep");
        check("fall_start_y", ypos, 290);
        clear_inputs();
        end_of_ramp = 1; landing_ypos = 12'd479;
        do_tick("fall");
        check("fall_enter", state, 3);
        end_of_ramp = 0;
        for (int i = 0; i < 10; i++) do_tick("fall");
        check("fall_vcap_y", ypos, 342);
        prev_y = ypos;
        do_tick("fall");
        check("fall_vcap_dy", int'(ypos) - prev_y, 8);
        for (int i = 0; i < 100 && state != 0; i++) do_tick("fall");
        check("fall_land_y", ypos, 479);
        check("fall_land_st", state, 0);
        $display("fall: y=%0d state=%0d", ypos, state);

        // Randomized frames
        for (int i = 0; i < 3000; i++) begin
            btn_left    = ($urandom_range(0, 2) == 0);
            btn_right   = ($urandom_range(0, 2) == 0);
            btn_up      = ($urandom_range(0, 2) == 0);
            btn_down    = ($urandom_range(0, 2) == 0);
            btn_jump    = ($urandom_range(0, 9) == 0);
            ladder      = ($urandom_range(0, 1) == 0);
            end_of_ramp = ($urandom_range(0, 19) == 0);
            ramp        = 2'($urandom_range(0, 3));
            limit_ypos_min = 12'(clampi(m_y - int'($urandom_range(0, 40)), 0, 4095));
            limit_ypos_max = 12'(clampi(m_y + int'($urandom_range(0, 40)), 0, 4095));
            landing_ypos   = 12'(clampi(m_y + int'($urandom_range(0, 200)), 0, 4095));
            if ($urandom_range(0, 7) == 0) idle_cycles(int'($urandom_range(1, 3)));
            do_tick("rand");
        end
        $display("random: 3000 frames, final x=%0d y=%0d state=%0d", xpos, ypos, state);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
